// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - machine-mode trap entry and MRET sequencer
// Walks IDLE -> READ -> WRITE -> REDIRECT over the implicit CSR ports and owns the privilege mode.
module trap_controller #(
  parameter logic [1:0] RESET_MODE  = 2'b11,
  parameter bit         VECTORED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         exc_valid,
  input  logic [4:0]   exc_cause,
  input  logic [31:0]  exc_tval,
  input  logic [31:0]  epc,
  input  logic         mret_valid,
  input  logic         irq_ext,
  input  logic         irq_timer,
  input  logic [127:0] impl_csr,
  output logic [47:0]  impl_addrs_r,
  output logic [3:0]   impl_read_enable,
  output logic [47:0]  impl_addrs_w,
  output logic [3:0]   impl_write_enable,
  output logic [127:0] impl_write_data,
  output logic         busy,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic [1:0]   mode
);
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d, mode_prev_q, mode_prev_d;
  logic        is_mret_q, is_mret_d;
  logic [31:0] cause_q, cause_d, tval_q, tval_d;
  logic [29:0] epc_q, epc_d;
  logic [31:0] mstatus_q, mstatus_d, vec_q, vec_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        irq_enabled, ext_take, timer_take, accept;
  logic [31:0] vec_base, trap_target, mstatus_trap, mstatus_mret;
  logic        unused_csr_bits;

  // Gating uses the mstatus/mie values presented on read ports 0/1 while idle.
  assign irq_enabled     = (mode_q != 2'b11) || impl_csr[3];
  assign ext_take        = irq_ext && impl_csr[32+11] && irq_enabled;
  assign timer_take      = irq_timer && impl_csr[32+7] && irq_enabled;
  assign accept          = (state_q == ST_IDLE) && (exc_valid || mret_valid || ext_take || timer_take);
  assign unused_csr_bits = ^impl_csr[127:32];

  assign vec_base    = {vec_q[31:2], 2'b00};
  assign trap_target = (VECTORED_EN && (vec_q[1:0] == 2'b01) && cause_q[31])
                       ? vec_base + {25'd0, cause_q[4:0], 2'b00} : vec_base;

  always_comb begin
    mstatus_trap        = mstatus_q;
    mstatus_trap[7]     = mstatus_q[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = mode_prev_q;
    mstatus_mret        = mstatus_q;
    mstatus_mret[3]     = mstatus_q[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mode_q        <= RESET_MODE;
      mode_prev_q   <= 2'b00;
      is_mret_q     <= 1'b0;
      cause_q       <= '0;
      tval_q        <= '0;
      epc_q         <= '0;
      mstatus_q     <= '0;
      vec_q         <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      mode_prev_q   <= mode_prev_d;
      is_mret_q     <= is_mret_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      epc_q         <= epc_d;
      mstatus_q     <= mstatus_d;
      vec_q         <= vec_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    mode_prev_d   = mode_prev_q;
    is_mret_d     = is_mret_q;
    cause_d       = cause_q;
    tval_d        = tval_q;
    epc_d         = epc_q;
    mstatus_d     = mstatus_q;
    vec_d         = vec_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_READ;
          mode_prev_d = mode_q;
          epc_d       = epc[31:2];
          tval_d      = '0;
          is_mret_d   = 1'b0;
          if (exc_valid) begin
            cause_d = {27'd0, exc_cause};
            tval_d  = exc_tval;
          end else if (mret_valid) begin
            is_mret_d = 1'b1;
            cause_d   = '0;
          end else if (ext_take) begin
            cause_d = {1'b1, 26'd0, 5'd11};
          end else begin
            cause_d = {1'b1, 26'd0, 5'd7};
          end
        end
      end
      ST_READ: begin
        state_d   = ST_WRITE;
        mstatus_d = impl_csr[31:0];
        vec_d     = impl_csr[63:32];
      end
      ST_WRITE: begin
        state_d = ST_REDIRECT;
        if (is_mret_q) begin
          mode_d        = mstatus_q[12:11];
          redirect_pc_d = vec_base;
        end else begin
          mode_d        = 2'b11;
          redirect_pc_d = trap_target;
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    impl_addrs_r      = '0;
    impl_read_enable  = '0;
    impl_addrs_w      = '0;
    impl_write_enable = '0;
    impl_write_data   = '0;
    case (state_q)
      ST_IDLE: begin
        impl_read_enable    = 4'b0011;
        impl_addrs_r[11:0]  = CSR_MSTATUS;
        impl_addrs_r[23:12] = CSR_MIE;
      end
      ST_READ: begin
        impl_read_enable    = 4'b0011;
        impl_addrs_r[11:0]  = CSR_MSTATUS;
        impl_addrs_r[23:12] = is_mret_q ? CSR_MEPC : CSR_MTVEC;
      end
      ST_WRITE: begin
        if (is_mret_q) begin
          impl_write_enable     = 4'b0001;
          impl_addrs_w[11:0]    = CSR_MSTATUS;
          impl_write_data[31:0] = mstatus_mret;
        end else begin
          impl_write_enable = 4'b1111;
          impl_addrs_w      = {CSR_MTVAL, CSR_MCAUSE, CSR_MEPC, CSR_MSTATUS};
          impl_write_data   = {tval_q, cause_q, {epc_q, 2'b00}, mstatus_trap};
        end
      end
      default: ;
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = redirect_pc_q;
  assign mode           = mode_q;

endmodule
